// File: rtl/mem_responder.sv
// Word-organised SRAM responder for the multi-cycle core memory port.
// Accepts one request at a time, adds wait states and reports faults.
module mem_responder #(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic        mem_rden,
    input  logic        mem_wren,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        done,
    output logic        fault
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        rd_q;
    logic        wr_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   offset;
    logic          in_range;
    logic          bad;
    logic          access;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wword;

    always_comb begin
        offset   = addr_q - BASE_ADDR;
        in_range = {1'b0, offset} < SPAN;
        idx      = offset[AW+1:2];
        access   = (state == WAIT) && (cnt == 4'd0);
        bad      = (rd_q && wr_q) || !in_range;
        if (wr_q) begin
            unique case (size_q)
                2'd1:    bad = bad || addr_q[0];
                2'd2:    bad = bad || (addr_q[1:0] != 2'b00);
                2'd3:    bad = 1'b1;
                default: ;
            endcase
        end
        be    = 4'b1111;
        wword = wdata_q;
        unique case (size_q)
            2'd0: begin
                be    = 4'b0001 << addr_q[1:0];
                wword = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (access && wr_q && !bad) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            size_q    <= 2'd0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            mem_rdata <= 32'h0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mem_rden || mem_wren) begin
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        size_q  <= mem_size;
                        rd_q    <= mem_rden;
                        wr_q    <= mem_wren;
                        cnt     <= 4'(WAIT_CYCLES);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (rd_q) mem_rdata <= bad ? 32'h0 : mem[idx];
                        done  <= 1'b1;
                        fault <= bad;
                        state <= RESP;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one zero-wait instance and one
// three-wait-state instance at a non-zero base address.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        rd0, wr0, rd3, wr3;
    logic [31:0] rdata0, rdata3;
    logic        done0, done3, fault0, fault3;

    int n_checks = 0;
    int n_fail   = 0;
    int dcnt0    = 0;
    int dcnt3    = 0;

    always #5 clk = ~clk;

    mem_responder #(
        .DEPTH_WORDS(4096),
        .WAIT_CYCLES(0),
        .BASE_ADDR(32'h0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(addr), .mem_rden(rd0), .mem_wren(wr0),
        .mem_size(size), .mem_wdata(wdata),
        .mem_rdata(rdata0), .done(done0), .fault(fault0)
    );

    mem_responder #(
        .DEPTH_WORDS(64),
        .WAIT_CYCLES(3),
        .BASE_ADDR(32'h1000)
    ) dut3 (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(addr), .mem_rden(rd3), .mem_wren(wr3),
        .mem_size(size), .mem_wdata(wdata),
        .mem_rdata(rdata3), .done(done3), .fault(fault3)
    );

    always @(posedge clk) begin
        if (done0) dcnt0++;
        if (done3) dcnt3++;
    end

    // Drive one request from a negedge, hold it until done, then idle a cycle.
    // lat counts negedges from the request to the one that sees done.
    task automatic req(input bit sel, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] wd, input bit tog,
                       output int lat, output bit ok, output bit flt,
                       output logic [31:0] rdo);
        addr  = a;
        size  = sz;
        wdata = wd;
        if (sel) begin rd3 = rd; wr3 = wr; end
        else     begin rd0 = rd; wr0 = wr; end
        ok  = 1'b0;
        lat = 0;
        flt = 1'b0;
        rdo = 32'h0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (sel ? done3 : done0) begin
                ok  = 1'b1;
                lat = i;
                flt = sel ? fault3 : fault0;
                rdo = sel ? rdata3 : rdata0;
                break;
            end
            if (tog && sel) rd3 = (i % 2 == 1);
        end
        rd0 = 1'b0; wr0 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rd0 = 1'b0; wr0 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
        addr = 32'h0; size = 2'd2; wdata = 32'h0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rdata0 !== 32'h0 || done0 !== 1'b0 || fault0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset0 rdata=%h done=%b fault=%b want 0/0/0",
                     rdata0, done0, fault0);
        end
        n_checks++;
        if (rdata3 !== 32'h0 || done3 !== 1'b0 || fault3 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset3 rdata=%h done=%b fault=%b want 0/0/0",
                     rdata3, done3, fault3);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_basic();
        int lat; bit ok, flt; logic [31:0] rd;
        req(0, 0, 1, 32'h0, 2'd2, 32'h0000_0013, 0, lat, ok, flt, rd);
        n_checks++;
        if (!ok || lat != 2 || flt) begin
            n_fail++;
            $display("FAIL wr_word0 ok=%b lat=%0d fault=%b want 1/2/0", ok, lat, flt);
        end
        req(0, 1, 0, 32'h0, 2'd2, 32'h0, 0, lat, ok, flt, rd);
        n_checks++;
        if (!ok || lat != 2 || flt || rd !== 32'h0000_0013) begin
            n_fail++;
            $display("FAIL rd_word0 ok=%b lat=%0d fault=%b rdata=%h want 1/2/0/00000013",
                     ok, lat, flt, rd);
        end
    endtask

    task automatic test_byte_half();
        int lat; bit ok, flt; logic [31:0] rd;
        req(0, 0, 1, 32'h4, 2'd2, 32'h1122_3344, 0, lat, ok, flt, rd);
        req(0, 0, 1, 32'h7, 2'd0, 32'hFFFF_FFAB, 0, lat, ok, flt, rd);
        n_checks++;
        if (!ok || flt) begin
            n_fail++;
            $display("FAIL byte_store ok=%b fault=%b want 1/0", ok, flt);
        end
        req(0, 1, 0, 32'h4, 2'd2, 32'h0, 0, lat, ok, flt, rd);
        n_checks++;
        if (rd !== 32'hAB22_3344) begin
            n_fail++;
            $display("FAIL byte_read rdata=%h want ab223344", rd);
        end
        req(0, 0, 1, 32'h6, 2'd1, 32'h0000_BEEF, 0, lat, ok, flt, rd);
        req(0, 1, 0, 32'h5, 2'd2, 32'h0, 0, lat, ok, flt, rd);
        n_checks++;
        if (rd !== 32'hBEEF_3344 || flt) begin
            n_fail++;
            $display("FAIL half_hi rdata=%h fault=%b want beef3344/0", rd, flt);
        end
        req(0, 0, 1, 32'h4, 2'd1, 32'h1234_5566, 0, lat, ok, flt, rd);
        req(0, 0, 1, 32'h5, 2'd0, 32'h0000_0077, 0, lat, ok, flt, rd);
        req(0, 1, 0, 32'h4, 2'd2, 32'h0, 0, lat, ok, flt, rd);
        n_checks++;
        if (rd !== 32'hBEEF_7766) begin
            n_fail++;
            $display("FAIL half_lo_byte1 rdata=%h want beef7766", rd);
        end
    endtask

    task automatic test_wait_states();
        int lat; bit ok, flt; logic [31:0] rd; int d0;
        req(1, 0, 1, 32'h1004, 2'd2, 32'h600D_F00D, 0, lat, ok, flt, rd);
        n_checks++;
        if (!ok || lat != 5 || flt) begin
            n_fail++;
            $display("FAIL wait_wr ok=%b lat=%0d fault=%b want 1/5/0", ok, lat, flt);
        end
        d0 = dcnt3;
        req(1, 1, 0, 32'h1004, 2'd2, 32'h0, 1, lat, ok, flt, rd);
        repeat (8) @(negedge clk);
        n_checks++;
        if (!ok || lat != 5 || rd !== 32'h600D_F00D || dcnt3 - d0 != 1) begin
            n_fail++;
            $display("FAIL wait_rd_toggle ok=%b lat=%0d rdata=%h dones=%0d want 1/5/600df00d/1",
                     ok, lat, rd, dcnt3 - d0);
        end
        req(1, 1, 0, 32'h0FFC, 2'd2, 32'h0, 0, lat, ok, flt, rd);
        n_checks++;
        if (!ok || !flt || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL below_base ok=%b fault=%b rdata=%h want 1/1/0", ok, flt, rd);
        end
        req(1, 1, 0, 32'h10FC, 2'd2, 32'h0, 0, lat, ok, flt, rd);
        n_checks++;
        if (!ok || flt) begin
            n_fail++;
            $display("FAIL top_word ok=%b fault=%b want 1/0", ok, flt);
        end
    endtask

    task automatic test_faults();
        int lat; bit ok, flt; logic [31:0] rd;
        req(0, 1, 0, 32'h0, 2'd2, 32'h0, 0, lat, ok, flt, rd);
        req(0, 0, 1, 32'h2, 2'd2, 32'hFFFF_FFFF, 0, lat, ok, flt, rd);
        n_checks++;
        if (!ok || lat != 2 || !flt || rdata0 !== 32'h0000_0013) begin
            n_fail++;
            $display("FAIL word_misalign ok=%b lat=%0d fault=%b rdata=%h want 1/2/1/00000013",
                     ok, lat, flt, rdata0);
        end
        req(0, 0, 1, 32'h1, 2'd1, 32'hFFFF_FFFF, 0, lat, ok, flt, rd);
        n_checks++;
        if (!flt) begin
            n_fail++;
            $display("FAIL half_misalign fault=%b want 1", flt);
        end
        req(0, 0, 1, 32'h0, 2'd3, 32'hFFFF_FFFF, 0, lat, ok, flt, rd);
        n_checks++;
        if (!flt) begin
            n_fail++;
            $display("FAIL size3 fault=%b want 1", flt);
        end
        req(0, 1, 0, 32'h0, 2'd2, 32'h0, 0, lat, ok, flt, rd);
        n_checks++;
        if (rd !== 32'h0000_0013 || flt) begin
            n_fail++;
            $display("FAIL sram_unchanged rdata=%h fault=%b want 00000013/0", rd, flt);
        end
        req(0, 1, 0, 32'h4000, 2'd2, 32'h0, 0, lat, ok, flt, rd);
        n_checks++;
        if (!ok || lat != 2 || !flt || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL out_of_range ok=%b lat=%0d fault=%b rdata=%h want 1/2/1/0",
                     ok, lat, flt, rd);
        end
        req(0, 1, 1, 32'h0, 2'd2, 32'h0, 0, lat, ok, flt, rd);
        n_checks++;
        if (!ok || !flt) begin
            n_fail++;
            $display("FAIL rd_and_wr ok=%b fault=%b want 1/1", ok, flt);
        end
        req(0, 1, 0, 32'h3, 2'd2, 32'h0, 0, lat, ok, flt, rd);
        n_checks++;
        if (flt || rd !== 32'h0000_0013) begin
            n_fail++;
            $display("FAIL rd_unaligned fault=%b rdata=%h want 0/00000013", flt, rd);
        end
    endtask

    task automatic test_reset_abort();
        int lat; bit ok, flt; logic [31:0] rd; int d0; bit seen;
        req(0, 0, 1, 32'h8, 2'd2, 32'hCAFE_F00D, 0, lat, ok, flt, rd);
        d0 = dcnt0;
        seen = 1'b0;
        addr = 32'h8; size = 2'd2; wdata = 32'hDEAD_BEEF; wr0 = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        wr0 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done0) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done0) seen = 1'b1;
        end
        n_checks++;
        if (seen || dcnt0 != d0 || rdata0 !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_done seen=%b dones=%0d rdata=%h want 0/0/0",
                     seen, dcnt0 - d0, rdata0);
        end
        req(0, 1, 0, 32'h8, 2'd2, 32'h0, 0, lat, ok, flt, rd);
        n_checks++;
        if (!ok || lat != 2 || flt || rd !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL abort_nowrite ok=%b lat=%0d fault=%b rdata=%h want 1/2/0/cafef00d",
                     ok, lat, flt, rd);
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit ok, flt; logic [31:0] rd; int d0;
        d0 = dcnt0;
        req(0, 0, 1, 32'h10, 2'd2, 32'h5A5A_5A5A, 0, lat, ok, flt, rd);
        req(0, 1, 0, 32'h10, 2'd2, 32'h0, 0, lat, ok, flt, rd);
        repeat (4) @(negedge clk);
        n_checks++;
        if (!ok || lat != 2 || rd !== 32'h5A5A_5A5A || dcnt0 - d0 != 2) begin
            n_fail++;
            $display("FAIL back_to_back ok=%b lat=%0d rdata=%h dones=%0d want 1/2/5a5a5a5a/2",
                     ok, lat, rd, dcnt0 - d0);
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_byte_half();
        test_wait_states();
        test_faults();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
